// File: rtl/cic_decimator.sv
// PDM-to-PCM decimator: ORDER-stage CIC (differential delay 1), one PDM bit in per clk,
// one WIDTH-bit two's-complement sample out every DECIM clocks. Define CIC_UNIPOLAR_EN for 0/+1 input mapping.
module cic_decimator #(
    parameter int ORDER = 4,
    parameter int DECIM = 32,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    output logic [WIDTH-1:0] val
);

    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] integ_q [ORDER];
    logic [WIDTH-1:0] integ_d [ORDER];
    logic [WIDTH-1:0] dly_q   [ORDER];
    logic [WIDTH-1:0] dly_d   [ORDER];
    logic [WIDTH-1:0] val_q, val_d;
    logic [WIDTH-1:0] x;
    logic             dump;

    always_comb begin
`ifdef CIC_UNIPOLAR_EN
        x = {{(WIDTH-1){1'b0}}, din};
`else
        x = din ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b1}};
`endif
    end

    // Integrator chain: each stage adds the registered value of the stage before it.
    always_comb begin
        integ_d[0] = integ_q[0] + x;
        for (int k = 1; k < ORDER; k++) begin
            integ_d[k] = integ_q[k] + integ_q[k-1];
        end
    end

    // DECIM is a power of two, so the counter wraps by plain overflow.
    always_comb begin
        dump  = (cnt_q == CW'(DECIM - 1));
        cnt_d = cnt_q + CW'(1);
    end

    always_comb begin
        logic [WIDTH-1:0] acc;
        acc   = integ_q[ORDER-1];
        val_d = val_q;
        for (int k = 0; k < ORDER; k++) begin
            dly_d[k] = dly_q[k];
        end
        if (dump) begin
            for (int k = 0; k < ORDER; k++) begin
                dly_d[k] = acc;
                acc      = acc - dly_q[k];
            end
            val_d = acc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            val_q <= '0;
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            val_q <= val_d;
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= integ_d[k];
                dly_q[k]   <= dly_d[k];
            end
        end
    end

    assign val = val_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator (default parameters); honours CIC_UNIPOLAR_EN.
module tb_cic_decimator;

    localparam int WIDTH = 24;
    localparam int DECIM = 32;
`ifdef CIC_UNIPOLAR_EN
    localparam bit UNIPOLAR = 1'b1;
`else
    localparam bit UNIPOLAR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             din;
    logic [WIDTH-1:0] val;

    int n_vec  = 0;
    int n_miss = 0;
    logic [WIDTH-1:0] exp_q[$];

    // Hand-computed unit-step response at updates 1..5 (zero state, 0/+1 input):
    // C(31,4), then the comb differences of C(63,4), C(95,4), C(127,4), C(159,4).
    int s_tab[5] = '{31465, 469805, 989675, 1048575, 1048576};

    cic_decimator #(.ORDER(4), .DECIM(DECIM), .WIDTH(WIDTH)) dut (
        .clk  (clk),
        .reset(reset),
        .din  (din),
        .val  (val)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic int step_resp(input int m);
        if (m <= 0) return 0;
        if (m > 5) return 1 << 20;
        return s_tab[m-1];
    endfunction

    // Input is 0 before update boundary jstep and 1 after; linear superposition of step responses.
    function automatic logic [WIDTH-1:0] model_val(input int j, input int jstep);
        int s_on;
        s_on = step_resp(j - jstep);
        if (UNIPOLAR) return WIDTH'(s_on);
        return WIDTH'(2 * s_on - step_resp(j));
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_val(input string tag, input logic [WIDTH-1:0] got,
                             input logic [WIDTH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: val=0x%06h expected 0x%06h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        reset = 1'b1;
        din   = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_hold", val, '0);
        reset = 1'b0;
    endtask

    // Starts from a freshly reset state, at a falling edge; din steps 0->1 after step_clk clocks.
    task automatic run_step(input int n_clk, input int step_clk, input string tag);
        for (int n = 1; n <= n_clk; n++) begin
            int j;
            j   = n / DECIM;
            din = (n > step_clk) ? 1'b1 : 1'b0;
            if (j == 0) exp_q.push_back('0);
            else        exp_q.push_back(model_val(j, step_clk / DECIM));
            @(posedge clk);
            #1;
            check_val($sformatf("%s@%0d", tag, n), val, exp_q.pop_front());
            @(negedge clk);
        end
    endtask

    // Alternating 1,0,... from reset; only settled updates (6th onward) are checked.
    task automatic run_alt(input int n_clk, input string tag);
        logic [WIDTH-1:0] steady;
        steady = UNIPOLAR ? 24'h080000 : 24'h000000;
        for (int n = 1; n <= n_clk; n++) begin
            din = n[0];
            if (n / DECIM >= 6) exp_q.push_back(steady);
            @(posedge clk);
            #1;
            if (n / DECIM >= 6) check_val($sformatf("%s@%0d", tag, n), val, exp_q.pop_front());
            @(negedge clk);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        reset = 1'b1;
        din   = 1'b0;

        do_reset();
        run_step(5, 1 << 30, "rst_din0");

        do_reset();
        run_step(70, 0, "pre_async");
        #2 reset = 1'b1;
        #1 check_val("async_clr", val, '0);
        repeat (2) @(negedge clk);
        check_val("async_hold", val, '0);
        reset = 1'b0;

        run_step(256, 0, "ones");

        do_reset();
        run_step(256, 1 << 30, "zeros");

        do_reset();
        run_alt(512, "alt");

        do_reset();
        run_step(512, 256, "step");

        do_reset();
        run_step(4096, 0, "wrap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
